// File: rtl/led_uart_tx_pkg.sv
// Shared definitions for the LED UART transmitter and its neighbours:
// transmitter FSM encodings, default baud divisor and the ALU opcodes.
package led_uart_tx_pkg;

  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_LED = 4'd7
  } alu_op_e;

  // Occupancy counter width: must be able to hold the value DEPTH itself
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/led_uart_tx_if.sv
// Byte strobe from the ALU plus serial line and status flags back.
interface led_uart_tx_if;
  logic [7:0] iData;
  logic       iValid;
  logic       oTx;
  logic       oBusy;
  logic       oFull;
  logic       oOverflow;

  modport master (output iData, iValid, input oTx, oBusy, oFull, oOverflow);
  modport slave  (input iData, iValid, output oTx, oBusy, oFull, oOverflow);
endinterface

// File: rtl/led_uart_tx_byte_fifo.sv
// Small byte queue with registered occupancy count; push is ignored when
// full and pop is ignored when empty so callers cannot corrupt the count.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointers, storage and occupancy; pointers wrap by natural overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/led_uart_tx.sv
// 8N1 serial transmitter for the ALU LED register: strobed bytes are queued
// and sent back-to-back, LSB first, with a registered, glitch-free line.
module led_uart_tx
  import led_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  led_uart_tx_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  tx_state_e        state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic             pop_s;
  logic             push_s;
  logic             bit_done_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  assign push_s     = bus.iValid & ~fifo_full_s;
  assign bit_done_s = (timer_q == 16'(CLKS_PER_BIT - 1));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.iData),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Frame sequencing: next state, bit timer, shift register and line level
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    // A strobe against a full queue is lost even if a pop frees a slot now
    ovf_d   = ovf_q | (bus.iValid & fifo_full_s);
    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        tx_d    = 1'b1;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          timer_d = 16'd0;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          timer_d = 16'd0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          timer_d = 16'd0;
          // Chain straight into the next start bit so frames have no gap
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        timer_d = 16'd0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Transmitter registers; reset aborts any frame and returns the line high
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.oTx       = tx_q;
  assign bus.oOverflow = ovf_q;
  assign bus.oFull     = fifo_full_s;
  assign bus.oBusy     = (state_q != IDLE) | (fifo_count_s != CNT_W'(0));

endmodule

// File: tb/tb_led_uart_tx.sv
// Directed bench for led_uart_tx: a fast instance (4 clocks per bit) for
// function and a real-rate instance (434 clocks per bit) for baud timing.
module tb_led_uart_tx;

  localparam int CPB = 4;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  led_uart_tx_if bus_a ();
  led_uart_tx_if bus_b ();

  led_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  led_uart_tx #(.CLKS_PER_BIT(434), .FIFO_DEPTH(4)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks oTx over one frame from cycle 'first' (cycle 0 = first start-bit cycle)
  task automatic expect_frame(input logic [7:0] data, input int first, input string tag);
    logic [9:0] frm;
    frm = {1'b1, data, 1'b0};
    for (int k = first; k < 10 * CPB; k++) begin
      chk(tag, 32'(bus_a.oTx), 32'(frm[k / CPB]));
      tick();
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus_a.iData = 8'h00; bus_a.iValid = 1'b0;
    bus_b.iData = 8'h00; bus_b.iValid = 1'b0;
    tick(); tick();
    chk("rst_tx",   32'(bus_a.oTx),       32'd1);
    chk("rst_busy", 32'(bus_a.oBusy),     32'd0);
    chk("rst_full", 32'(bus_a.oFull),     32'd0);
    chk("rst_ovf",  32'(bus_a.oOverflow), 32'd0);
    chk("rst_b",    32'({bus_b.oTx, bus_b.oBusy}), 32'h2);
    Reset = 1'b0;
    tick();

    // iData wiggling without iValid must do nothing
    for (int i = 0; i < 4; i++) begin
      bus_a.iData = 8'(8'hC3 + i);
      tick();
      chk("novalid", 32'({bus_a.oTx, bus_a.oBusy}), 32'h2);
    end

    // Single byte 0x55: start one cycle after the strobe edge, idle at E0+41
    bus_a.iData = 8'h55; bus_a.iValid = 1'b1;
    tick();                               // E0
    bus_a.iValid = 1'b0;
    chk("lat_tx",   32'(bus_a.oTx),   32'd1);
    chk("lat_busy", 32'(bus_a.oBusy), 32'd1);
    tick();                               // E0+1
    expect_frame(8'h55, 0, "f55");        // ends at E0+41
    chk("f55_idle", 32'({bus_a.oTx, bus_a.oBusy}), 32'h2);

    // Back-to-back 0xA5 then 0x3C: 80 contiguous frame cycles
    bus_a.iData = 8'hA5; bus_a.iValid = 1'b1;
    tick();                               // E0
    bus_a.iData = 8'h3C;
    tick();                               // E0+1: pop and push together
    bus_a.iValid = 1'b0;
    expect_frame(8'hA5, 0, "fA5");
    expect_frame(8'h3C, 0, "f3C");        // start bit at E0+41
    chk("b2b_ovf",  32'(bus_a.oOverflow), 32'd0);
    chk("b2b_idle", 32'({bus_a.oTx, bus_a.oBusy}), 32'h2);

    // Push on the popping edge with one byte queued: 0x77 follows with no gap
    bus_a.iData = 8'h5A; bus_a.iValid = 1'b1;
    tick();
    bus_a.iData = 8'h77;
    tick();
    bus_a.iValid = 1'b0;
    chk("pp_full", 32'(bus_a.oFull), 32'd0);
    chk("pp_busy", 32'(bus_a.oBusy), 32'd1);
    expect_frame(8'h5A, 0, "f5A");
    expect_frame(8'h77, 0, "f77");
    chk("pp_idle", 32'({bus_a.oTx, bus_a.oBusy}), 32'h2);

    // Overflow: 0x01..0x06 on E0..E5; E1 pops 0x01, so the queue fills at E4
    for (int i = 0; i < 6; i++) begin
      bus_a.iData = 8'(i + 1); bus_a.iValid = 1'b1;
      tick();
      if (i == 3) chk("ovf_notfull", 32'(bus_a.oFull), 32'd0);
      if (i == 4) begin
        chk("ovf_full",   32'(bus_a.oFull),     32'd1);
        chk("ovf_before", 32'(bus_a.oOverflow), 32'd0);
      end
    end
    bus_a.iValid = 1'b0;
    chk("ovf_set",   32'(bus_a.oOverflow), 32'd1);
    chk("ovf_full2", 32'(bus_a.oFull),     32'd1);
    expect_frame(8'h01, 4, "f01");        // 0x01 started at E1, now at E5
    expect_frame(8'h02, 0, "f02");
    expect_frame(8'h03, 0, "f03");
    expect_frame(8'h04, 0, "f04");
    expect_frame(8'h05, 0, "f05");
    chk("ovf_idle",   32'({bus_a.oTx, bus_a.oBusy}), 32'h2);
    chk("ovf_sticky", 32'(bus_a.oOverflow), 32'd1);

    // Reset in DATA of 0xFF with two bytes queued; strobe on the reset edge
    for (int i = 0; i < 3; i++) begin
      bus_a.iData = (i == 0) ? 8'hFF : ((i == 1) ? 8'h11 : 8'h22);
      bus_a.iValid = 1'b1;
      tick();
    end
    bus_a.iValid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 32'(bus_a.oBusy), 32'd1);
    chk("mid_ovf",  32'(bus_a.oOverflow), 32'd1);
    Reset = 1'b1; bus_a.iData = 8'h99; bus_a.iValid = 1'b1;
    tick();
    Reset = 1'b0; bus_a.iValid = 1'b0;
    chk("mr_tx",   32'(bus_a.oTx),       32'd1);
    chk("mr_busy", 32'(bus_a.oBusy),     32'd0);
    chk("mr_full", 32'(bus_a.oFull),     32'd0);
    chk("mr_ovf",  32'(bus_a.oOverflow), 32'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("mr_quiet", 32'({bus_a.oTx, bus_a.oBusy}), 32'h2);
    end

    // Real baud divisor with 0x00: 9 low bits = 3906 cycles, stop 434 cycles
    bus_b.iData = 8'h00; bus_b.iValid = 1'b1;
    tick();
    bus_b.iValid = 1'b0;
    tick();
    n = 0;
    while (bus_b.oTx === 1'b0 && n < 5000) begin
      n++;
      tick();
    end
    chk("baud_low", 32'(n), 32'd3906);
    n = 0;
    while (bus_b.oBusy === 1'b1 && bus_b.oTx === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    chk("baud_stop", 32'(n), 32'd434);
    chk("baud_idle", 32'({bus_b.oTx, bus_b.oBusy}), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_uart_tx.md
LED_UART_TX -- requirements
Module: led_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries in the holding queue; power of two, 2..16.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iData  input  8  byte from the ALU LED output register.
REQ-006 SHALL have port iValid  input  1  one-cycle strobe (the ALU LED-register enable); iData is valid in the same cycle.
REQ-007 SHALL have port oTx  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port oBusy  output  1  high while a frame is on the line or the queue is non-empty.
REQ-009 SHALL have port oFull  output  1  high when the queue holds FIFO_DEPTH bytes.
REQ-010 SHALL have port oOverflow  output  1  sticky flag: a strobed byte was dropped.

Function
REQ-011 SHALL write iData into the queue on every rising edge where iValid=1 and oFull=0.
REQ-012 SHALL drop the byte when iValid=1 and oFull=1, and SHALL set oOverflow on that edge, even if a pop occurs on the same edge.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL, in IDLE with the queue non-empty, pop the head on the next edge, load it into the shift register, enter START, and drive oTx=0 from that edge.
REQ-015 SHALL make the start-bit latency exactly one cycle: a byte written at edge E0 into an empty queue while in IDLE starts its start bit at edge E0+1.
REQ-016 SHALL hold each of the start, 8 data and stop bits on oTx for exactly CLKS_PER_BIT cycles, timed by a 16-bit bit-timer.
REQ-017 SHALL send data LSB first, with a 3-bit index counting 0..7 in DATA.
REQ-018 SHALL drive oTx=1 in STOP.
REQ-019 SHALL, on the last STOP cycle, go directly to START and pop the next byte if the queue is non-empty (no idle gap, exactly 10*CLKS_PER_BIT cycles per frame); otherwise it SHALL go to IDLE.
REQ-020 SHALL, on a simultaneous push and pop, keep the queue count unchanged and send the bytes in arrival order.
REQ-021 SHALL derive oFull from a registered count of width log2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL register oTx (glitch-free); oBusy = (state != IDLE) | (count != 0).
REQ-023 SHALL have no side effect from iData when iValid=0.

Reset
REQ-024 SHALL, on Reset=1 at a rising edge, set state=IDLE, oTx=1, queue empty, oFull=0, oBusy=0, oOverflow=0, and clear the bit-timer and bit index.
REQ-025 SHALL, on Reset during a frame, abort the frame: oTx returns high on that edge, and the partially sent and queued bytes are discarded.
REQ-026 SHALL give Reset priority over iValid on the same edge; that byte is not stored.
REQ-027 SHALL keep oOverflow set until Reset; no other clear.

Structure
REQ-028 SHALL place the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT in the shared definitions include file, alongside the ALU opcodes.
REQ-029 SHALL implement the queue as one sub-module, byte_fifo (parameterised depth, push/pop/full/empty/count, synchronous reset); the FSM, bit-timer and shift register stay in led_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-030 SHALL cover single byte: iValid with 0x55 at E0 -> oTx low at E0+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles, IDLE at E0+41, oBusy falls then.
REQ-031 SHALL cover back-to-back: 0xA5 at E0, 0x3C at E0+1 -> 80 contiguous cycles of frames (0xA5 then 0x3C), second start bit at E0+41, oOverflow=0.
REQ-032 SHALL cover overflow: six strobes 0x01..0x06 on E0..E5 -> oFull=1 after E4, 0x06 dropped, oOverflow=1 from E5; bytes 0x01..0x05 transmitted in order.
REQ-033 SHALL cover reset mid-frame: Reset asserted during DATA of 0xFF with 2 bytes queued -> oTx=1, oBusy=0, oFull=0, oOverflow=0 after that edge; no further frames.
REQ-034 SHALL cover simultaneous push/pop: queue holds 1 byte in IDLE, and iValid with 0x77 on the popping edge -> count stays 1, 0x77 sent next with no gap.
REQ-035 SHALL cover baud-timing check: CLKS_PER_BIT=434 with 0x00 -> start bit plus 8 data bits low for 3906 cycles, stop high for 434.
